// File: rtl/serial_tx_piso_if.sv
// Load/data request side and serial line status of the PISO frame transmitter.
// master drives LOAD/DIN; slave (the transmitter) drives TXD/BUSY/DONE.
interface serial_tx_piso_if #(
    parameter int WIDTH = 8
);
    logic             LOAD;
    logic [WIDTH-1:0] DIN;
    logic             TXD;
    logic             BUSY;
    logic             DONE;

    modport master (
        output LOAD, DIN,
        input  TXD, BUSY, DONE
    );

    modport slave (
        input  LOAD, DIN,
        output TXD, BUSY, DONE
    );
endinterface

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start, data LSB first,
// optional parity, stop. All state moves on the falling edge of C.
module serial_tx_piso #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              C,
    input  logic              RE,
    serial_tx_piso_if.slave   bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (div_q == DIV_LAST);

    always_ff @(negedge C or posedge RE) begin
        if (RE) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        div_d   = div_q;
        par_d   = par_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != IDLE) div_d = div_q + DW'(1);
        unique case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.LOAD) begin
                    sh_d    = bus.DIN;
                    par_d   = (^bus.DIN) ^ (PARITY_ODD != 0);
                    state_d = START;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    div_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // next bit comes from position 1 before the shift lands
                        bit_d = bit_q + BW'(1);
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    div_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign bus.TXD  = txd_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: four parameter variants share C/RE.
// Outputs are sampled 2 time units after each falling edge.
module tb_serial_tx_piso;
    logic C;
    logic RE;
    int   checks;
    int   errors;

    serial_tx_piso_if #(.WIDTH(8)) if0 ();
    serial_tx_piso_if #(.WIDTH(8)) if1 ();
    serial_tx_piso_if #(.WIDTH(8)) if2 ();
    serial_tx_piso_if #(.WIDTH(8)) if3 ();

    serial_tx_piso #(.WIDTH(8)) u0 (.C(C), .RE(RE), .bus(if0));
    serial_tx_piso #(.WIDTH(8), .PARITY_ODD(1)) u1 (.C(C), .RE(RE), .bus(if1));
    serial_tx_piso #(.WIDTH(8), .PARITY_EN(0)) u2 (.C(C), .RE(RE), .bus(if2));
    serial_tx_piso #(.WIDTH(8), .CLKS_PER_BIT(4)) u3 (.C(C), .RE(RE), .bus(if3));

    initial C = 1'b1;
    always #5 C = ~C;

    typedef struct {
        logic       load;
        logic [7:0] din;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic drive(input int sel, input logic ld, input logic [7:0] d);
        case (sel)
            0: begin if0.LOAD = ld; if0.DIN = d; end
            1: begin if1.LOAD = ld; if1.DIN = d; end
            2: begin if2.LOAD = ld; if2.DIN = d; end
            default: begin if3.LOAD = ld; if3.DIN = d; end
        endcase
    endtask

    function automatic logic [2:0] outs(input int sel);
        case (sel)
            0: return {if0.TXD, if0.BUSY, if0.DONE};
            1: return {if1.TXD, if1.BUSY, if1.DONE};
            2: return {if2.TXD, if2.BUSY, if2.DONE};
            default: return {if3.TXD, if3.BUSY, if3.DONE};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [2:0] got,
                       input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: txd/busy/done got %b required %b", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge C);
        #2;
    endtask

    task automatic accept(input int sel, input logic [7:0] d);
        drive(sel, 1'b1, d);
        tick();
    endtask

    // bits[i] is the i-th serial bit of the frame, start bit at index 0
    task automatic body(input string tag, input int sel, input logic [15:0] bits,
                        input int nb, input int cpb, input int ign,
                        input bit chg, input bit hold,
                        input logic [7:0] din, input logic [7:0] din2);
        for (int i = 0; i < nb * cpb; i++) begin
            chk($sformatf("%s c%0d", tag, i), outs(sel),
                {bits[i / cpb], 1'b1, 1'b0});
            if (hold) drive(sel, 1'b1, din2);
            else if (i == ign) drive(sel, 1'b1, 8'h3C);
            else drive(sel, 1'b0, chg ? ~din : din);
            tick();
        end
        chk({tag, " done"}, outs(sel), 3'b101);
        if (!hold) begin
            drive(sel, 1'b0, 8'h00);
            tick();
            chk({tag, " idle1"}, outs(sel), 3'b100);
            tick();
            chk({tag, " idle2"}, outs(sel), 3'b100);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RE = 1'b1;
        for (int s = 0; s < 4; s++) drive(s, 1'b1, 8'hA5);
        #1;
        for (int s = 0; s < 4; s++) chk($sformatf("reset async u%0d", s), outs(s), 3'b100);
        #3;
        for (int s = 0; s < 4; s++) chk($sformatf("reset midC u%0d", s), outs(s), 3'b100);
        tick();
        tick();
        for (int s = 0; s < 4; s++) chk($sformatf("reset 2cyc u%0d", s), outs(s), 3'b100);
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00);
        @(posedge C);
        RE = 1'b0;
        tick();

        // A5 frame: 0 | 1 0 1 0 0 1 0 1 | parity 0 | stop 1
        tbl[0]  = '{1'b1, 8'hA5, 3'b010};
        tbl[1]  = '{1'b0, 8'h00, 3'b110};
        tbl[2]  = '{1'b0, 8'h00, 3'b010};
        tbl[3]  = '{1'b0, 8'h00, 3'b110};
        tbl[4]  = '{1'b0, 8'h00, 3'b010};
        tbl[5]  = '{1'b0, 8'h00, 3'b010};
        tbl[6]  = '{1'b0, 8'h00, 3'b110};
        tbl[7]  = '{1'b0, 8'h00, 3'b010};
        tbl[8]  = '{1'b0, 8'h00, 3'b110};
        tbl[9]  = '{1'b0, 8'h00, 3'b010};
        tbl[10] = '{1'b0, 8'h00, 3'b110};
        tbl[11] = '{1'b0, 8'h00, 3'b101};
        tbl[12] = '{1'b0, 8'h00, 3'b100};
        for (int i = 0; i < 13; i++) begin
            drive(0, tbl[i].load, tbl[i].din);
            tick();
            chk($sformatf("basic A5 v%0d", i), outs(0), tbl[i].exp);
        end

        accept(1, 8'h07);
        body("odd 07", 1, 16'h040E, 11, 1, -1, 1'b0, 1'b0, 8'h07, 8'h00);

        accept(2, 8'hFF);
        body("nopar FF", 2, 16'h03FE, 10, 1, -1, 1'b0, 1'b0, 8'hFF, 8'h00);

        accept(0, 8'hA5);
        body("ignore A5", 0, 16'h054A, 11, 1, 3, 1'b1, 1'b0, 8'hA5, 8'h00);

        accept(0, 8'h01);
        body("b2b 01", 0, 16'h0602, 11, 1, -1, 1'b0, 1'b1, 8'h01, 8'h80);
        tick();
        body("b2b 80", 0, 16'h0700, 11, 1, -1, 1'b0, 1'b0, 8'h80, 8'h00);

        accept(3, 8'h55);
        body("div4 55", 3, 16'h04AA, 11, 4, -1, 1'b0, 1'b0, 8'h55, 8'h00);

        accept(0, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 8'hA5);
            tick();
        end
        chk("mid bit3", outs(0), 3'b010);
        #1;
        RE = 1'b1;
        #1;
        chk("mid abort", outs(0), 3'b100);
        tick();
        chk("mid held", outs(0), 3'b100);
        @(posedge C);
        RE = 1'b0;
        tick();
        chk("mid after", outs(0), 3'b100);
        accept(0, 8'h5A);
        body("post 5A", 0, 16'h04B4, 11, 1, -1, 1'b0, 1'b0, 8'h5A, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
